// File: rtl/issue_queue_age.sv
// Out-of-order issue queue: age-matrix oldest-ready select, multi-port tag wakeup,
// and ROB-mask flush. Payload is carried opaquely to register read.
module issue_queue_age #(
  parameter  int DEPTH     = 8,
  parameter  int PTAG_W    = 7,
  parameter  int ROB_W     = 3,
  parameter  int NUM_FU    = 8,
  parameter  int NUM_WAKE  = 2,
  parameter  int PAYLOAD_W = 96,
  localparam int FU_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int ROB_N     = 2 ** ROB_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [PTAG_W-1:0]          disp_rs1,
  input  logic [PTAG_W-1:0]          disp_rs2,
  input  logic                       disp_rs1_rdy,
  input  logic                       disp_rs2_rdy,
  input  logic [FU_W-1:0]            disp_fu_sel,
  input  logic [ROB_W-1:0]           disp_rob_idx,
  input  logic [PAYLOAD_W-1:0]       disp_payload,
  input  logic [NUM_WAKE-1:0]        wake_valid,
  input  logic [NUM_WAKE*PTAG_W-1:0] wake_tag,
  input  logic [NUM_FU-1:0]          fu_ready,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [PTAG_W-1:0]          issue_rs1,
  output logic [PTAG_W-1:0]          issue_rs2,
  output logic [FU_W-1:0]            issue_fu_sel,
  output logic [ROB_W-1:0]           issue_rob_idx,
  output logic [PAYLOAD_W-1:0]       issue_payload,
  input  logic                       flush_valid,
  input  logic [ROB_N-1:0]           flush_mask,
  output logic [CNT_W-1:0]           count
);

  localparam int IDX_W = $clog2(DEPTH);

  // Entry state
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     rs1_rdy_q, rs2_rdy_q;
  logic [PTAG_W-1:0]    rs1_q     [DEPTH];
  logic [PTAG_W-1:0]    rs2_q     [DEPTH];
  logic [FU_W-1:0]      fu_q      [DEPTH];
  logic [ROB_W-1:0]     rob_q     [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  // age_q[i][j] = 1 : entry i is older than entry j
  logic [DEPTH-1:0]     age_q     [DEPTH];
  logic [DEPTH-1:0]     age_d     [DEPTH];
  logic [CNT_W-1:0]     count_q, count_d;

  // Per-entry combinational status
  logic [DEPTH-1:0] hit1, hit2, killed, req, older, gnt_oh, stay;
  logic [IDX_W-1:0] gnt_idx, free_idx;
  logic             gnt_found;
  logic             issue_fire, disp_fire, disp_kill, disp_write;
  logic             disp_hit1, disp_hit2;
  logic [CNT_W-1:0] n_flushed;

  // Tag 0 is the hardwired zero register and never matches a broadcast.
  function automatic logic wake_hit(input logic [PTAG_W-1:0]          tag,
                                    input logic [NUM_WAKE-1:0]        wv,
                                    input logic [NUM_WAKE*PTAG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WAKE; k++) begin
      if (wv[k] && (tag != '0) && (wt[k*PTAG_W +: PTAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    hit1   = '0;
    hit2   = '0;
    killed = '0;
    req    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i]   = wake_hit(rs1_q[i], wake_valid, wake_tag);
      hit2[i]   = wake_hit(rs2_q[i], wake_valid, wake_tag);
      killed[i] = flush_valid && flush_mask[rob_q[i]];
      req[i]    = valid_q[i] && (rs1_rdy_q[i] || hit1[i]) && (rs2_rdy_q[i] || hit2[i])
                  && fu_ready[fu_q[i]] && !killed[i];
    end
  end

  // Oldest-ready select; a corrupted (cyclic) age matrix falls back to lowest index.
  always_comb begin
    older     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && req[j] && age_q[j][i]) older[i] = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!gnt_found && req[i] && !older[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!gnt_found && req[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(i);
      end
    end
    gnt_oh = gnt_found ? (DEPTH'(1) << gnt_idx) : '0;
  end

  assign issue_valid = |req;
  assign issue_fire  = issue_valid && issue_ready;

  always_comb begin
    issue_rs1     = '0;
    issue_rs2     = '0;
    issue_fu_sel  = '0;
    issue_rob_idx = '0;
    issue_payload = '0;
    if (issue_valid) begin
      issue_rs1     = rs1_q[gnt_idx];
      issue_rs2     = rs2_q[gnt_idx];
      issue_fu_sel  = fu_q[gnt_idx];
      issue_rob_idx = rob_q[gnt_idx];
      issue_payload = payload_q[gnt_idx];
    end
  end

  // Dispatch targets the lowest free slot as seen at the start of the cycle.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign disp_ready = (count_q < CNT_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  assign disp_kill  = flush_valid && flush_mask[disp_rob_idx];
  assign disp_write = disp_fire && !disp_kill;
  assign disp_hit1  = wake_hit(disp_rs1, wake_valid, wake_tag);
  assign disp_hit2  = wake_hit(disp_rs2, wake_valid, wake_tag);

  assign stay = valid_q & ~killed & ~(issue_fire ? gnt_oh : '0);

  always_comb begin
    valid_d   = stay;
    n_flushed = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i]  = age_q[i];
      n_flushed = n_flushed + CNT_W'(valid_q[i] & killed[i]);
    end
    if (disp_write) begin
      valid_d[free_idx] = 1'b1;
      age_d[free_idx]   = '0;
      for (int j = 0; j < DEPTH; j++) begin
        age_d[j][free_idx] = stay[j];
      end
    end
    count_d = count_q + CNT_W'(disp_write) - CNT_W'(issue_fire) - n_flushed;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      age_q   <= age_d;
    end
  end

  // NOTE: entry fields are qualified by valid_q, so this storage needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_write && (free_idx == IDX_W'(i))) begin
        rs1_q[i]     <= disp_rs1;
        rs2_q[i]     <= disp_rs2;
        rs1_rdy_q[i] <= disp_rs1_rdy | disp_hit1;
        rs2_rdy_q[i] <= disp_rs2_rdy | disp_hit2;
        fu_q[i]      <= disp_fu_sel;
        rob_q[i]     <= disp_rob_idx;
        payload_q[i] <= disp_payload;
      end else begin
        rs1_rdy_q[i] <= rs1_rdy_q[i] | hit1[i];
        rs2_rdy_q[i] <= rs2_rdy_q[i] | hit2[i];
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_issue_queue_age.sv
// Directed bench for issue_queue_age: stimulus pushes expected issues into a
// scoreboard queue; a monitor pops and compares on every issue handshake.
module tb_issue_queue_age;

  localparam int DEPTH = 8, PTAG_W = 7, ROB_W = 3, NUM_FU = 8, NUM_WAKE = 2, PAYLOAD_W = 96;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid, disp_ready;
  logic [6:0]  disp_rs1, disp_rs2;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [2:0]  disp_fu_sel, disp_rob_idx;
  logic [95:0] disp_payload;
  logic [1:0]  wake_valid;
  logic [13:0] wake_tag;
  logic [7:0]  fu_ready;
  logic        issue_valid, issue_ready;
  logic [6:0]  issue_rs1, issue_rs2;
  logic [2:0]  issue_fu_sel, issue_rob_idx;
  logic [95:0] issue_payload;
  logic        flush_valid;
  logic [7:0]  flush_mask;
  logic [3:0]  count;

  issue_queue_age #(
    .DEPTH(DEPTH), .PTAG_W(PTAG_W), .ROB_W(ROB_W),
    .NUM_FU(NUM_FU), .NUM_WAKE(NUM_WAKE), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_fu_sel(disp_fu_sel), .disp_rob_idx(disp_rob_idx), .disp_payload(disp_payload),
    .wake_valid(wake_valid), .wake_tag(wake_tag), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_fu_sel(issue_fu_sel), .issue_rob_idx(issue_rob_idx), .issue_payload(issue_payload),
    .flush_valid(flush_valid), .flush_mask(flush_mask), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  rs1;
    logic [6:0]  rs2;
    logic [2:0]  fu;
    logic [2:0]  rob;
    logic [95:0] payload;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one dispatch; if it is expected to issue, its response goes to the scoreboard now.
  task automatic disp(input logic [6:0] r1, input logic r1r, input logic [6:0] r2, input logic r2r,
                      input logic [2:0] fu, input logic [2:0] rob, input logic [95:0] pl,
                      input bit will_issue);
    disp_valid   = 1'b1;
    disp_rs1     = r1;
    disp_rs1_rdy = r1r;
    disp_rs2     = r2;
    disp_rs2_rdy = r2r;
    disp_fu_sel  = fu;
    disp_rob_idx = rob;
    disp_payload = pl;
    if (will_issue) exp_q.push_back('{rs1: r1, rs2: r2, fu: fu, rob: rob, payload: pl});
  endtask

  // Monitor: compare every issue handshake against the oldest scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_issue: got rob %0d rs1 %0d, expected no issue (t=%0t)",
                   issue_rob_idx, issue_rs1, $time);
        end else begin
          e = exp_q.pop_front();
          check("issue_rs1",     issue_rs1,     e.rs1);
          check("issue_rs2",     issue_rs2,     e.rs2);
          check("issue_fu_sel",  issue_fu_sel,  e.fu);
          check("issue_rob_idx", issue_rob_idx, e.rob);
          check("issue_payload", issue_payload, e.payload);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    disp_valid = 1'b0; disp_rs1 = '0; disp_rs2 = '0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
    disp_fu_sel = '0; disp_rob_idx = '0; disp_payload = '0;
    wake_valid = '0; wake_tag = '0; fu_ready = 8'hFF; issue_ready = 1'b0;
    flush_valid = 1'b0; flush_mask = '0;
    repeat (2) cyc();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_count",       count,         4'd0);
    check("rst_issue_valid", issue_valid,   1'b0);
    check("rst_disp_ready",  disp_ready,    1'b1);
    check("rst_issue_rs1",   issue_rs1,     7'd0);
    check("rst_payload",     issue_payload, 96'd0);
    cyc();

    // Single ready op issues the cycle after dispatch
    issue_ready = 1'b1;
    disp(7'd5, 1'b1, 7'd0, 1'b1, 3'd2, 3'd0, 96'hA1, 1'b1);
    @(negedge clk);
    check("t1_disp_ready", disp_ready,  1'b1);
    check("t1_empty_iv",   issue_valid, 1'b0);
    cyc();
    disp_valid = 1'b0;
    @(negedge clk);
    check("t1_issue_valid", issue_valid, 1'b1);
    check("t1_count1",      count,       4'd1);
    cyc();
    @(negedge clk);
    check("t1_count0", count, 4'd0);
    cyc();

    // Oldest-first: A waits on tag 9, B and C ready; wake 9 on port 1
    issue_ready = 1'b0;
    disp(7'd9,  1'b0, 7'd0,  1'b1, 3'd1, 3'd1, 96'hB0A, 1'b1);
    cyc();
    disp(7'd10, 1'b1, 7'd11, 1'b1, 3'd3, 3'd2, 96'hB0B, 1'b1);
    cyc();
    disp(7'd12, 1'b1, 7'd0,  1'b1, 3'd4, 3'd3, 96'hB0C, 1'b1);
    @(negedge clk);
    check("t2_b_requests", issue_rob_idx, 3'd2);
    cyc();
    disp_valid  = 1'b0;
    issue_ready = 1'b1;
    wake_valid  = 2'b10;
    wake_tag    = {7'd9, 7'd0};
    @(negedge clk);
    check("t2_count3",   count,       4'd3);
    check("t2_wake_iss", issue_valid, 1'b1);
    cyc();
    wake_valid = 2'b00;
    wake_tag   = '0;
    cyc();
    cyc();
    @(negedge clk);
    check("t2_count0", count, 4'd0);
    cyc();

    // Fill all entries with waiting ops; full stalls dispatch
    for (int i = 0; i < 8; i++) begin
      disp(7'(20 + i), 1'b0, 7'd0, 1'b1, 3'(i), 3'(i), 96'hC00 + 96'(i), i == 3);
      cyc();
    end
    disp(7'd50, 1'b1, 7'd0, 1'b1, 3'd0, 3'd7, 96'hDEAD, 1'b0);
    @(negedge clk);
    check("t3_full_count", count,       4'd8);
    check("t3_full_ready", disp_ready,  1'b0);
    check("t3_full_iv",    issue_valid, 1'b0);
    cyc();
    disp_valid = 1'b0;
    wake_valid = 2'b01;
    wake_tag   = {7'd0, 7'd23};
    @(negedge clk);
    check("t3_stall_count", count,       4'd8);
    check("t3_wake_iss",    issue_valid, 1'b1);
    cyc();
    wake_valid = 2'b00;
    wake_tag   = '0;
    disp(7'd40, 1'b0, 7'd0, 1'b1, 3'd5, 3'd3, 96'hC40, 1'b1);
    @(negedge clk);
    check("t3_freed_count", count,      4'd7);
    check("t3_freed_ready", disp_ready, 1'b1);
    cyc();
    disp_valid = 1'b0;
    @(negedge clk);
    check("t3_refill_count", count,      4'd8);
    check("t3_refill_ready", disp_ready, 1'b0);
    cyc();
    wake_valid = 2'b10;
    wake_tag   = {7'd40, 7'd0};
    @(negedge clk);
    check("t3_d_iss", issue_valid, 1'b1);
    cyc();
    wake_valid  = 2'b00;
    wake_tag    = '0;
    flush_valid = 1'b1;
    flush_mask  = 8'hFF;
    @(negedge clk);
    check("t3_pre_flush", count, 4'd7);
    cyc();
    flush_valid = 1'b0;
    flush_mask  = '0;
    @(negedge clk);
    check("t3_flushed_count", count,      4'd0);
    check("t3_flushed_ready", disp_ready, 1'b1);
    cyc();

    // Flush kills rob 1 and 2 (oldest), rob 3 wins; masked dispatch is dropped
    issue_ready = 1'b0;
    disp(7'd13, 1'b1, 7'd0, 1'b1, 3'd1, 3'd1, 96'hD01, 1'b0);
    cyc();
    disp(7'd14, 1'b1, 7'd0, 1'b1, 3'd2, 3'd2, 96'hD02, 1'b0);
    cyc();
    disp(7'd15, 1'b1, 7'd0, 1'b1, 3'd3, 3'd3, 96'hD03, 1'b1);
    cyc();
    disp(7'd16, 1'b1, 7'd0, 1'b1, 3'd4, 3'd2, 96'hD04, 1'b0);
    flush_valid = 1'b1;
    flush_mask  = 8'b0000_0110;
    @(negedge clk);
    check("t4_flush_rob",   issue_rob_idx, 3'd3);
    check("t4_flush_iv",    issue_valid,   1'b1);
    check("t4_count3",      count,         4'd3);
    check("t4_disp_ready",  disp_ready,    1'b1);
    cyc();
    flush_valid = 1'b0;
    flush_mask  = '0;
    disp_valid  = 1'b0;
    issue_ready = 1'b1;
    @(negedge clk);
    check("t4_count1", count, 4'd1);
    cyc();
    @(negedge clk);
    check("t4_count0", count,       4'd0);
    check("t4_empty",  issue_valid, 1'b0);
    cyc();

    // Same-cycle wake at dispatch stores ready; tag 0 broadcasts wake nothing
    issue_ready = 1'b0;
    disp(7'd0, 1'b1, 7'd12, 1'b0, 3'd6, 3'd4, 96'hE04, 1'b1);
    wake_valid = 2'b01;
    wake_tag   = {7'd0, 7'd12};
    @(negedge clk);
    check("t5_disp_iv", issue_valid, 1'b0);
    cyc();
    wake_valid = 2'b00;
    wake_tag   = '0;
    disp(7'd0, 1'b0, 7'd0, 1'b1, 3'd0, 3'd5, 96'hE05, 1'b0);
    @(negedge clk);
    check("t5_stored_ready", issue_valid,   1'b1);
    check("t5_stored_rob",   issue_rob_idx, 3'd4);
    cyc();
    disp_valid  = 1'b0;
    issue_ready = 1'b1;
    wake_valid  = 2'b11;
    wake_tag    = '0;
    @(negedge clk);
    check("t5_e_iss", issue_valid, 1'b1);
    cyc();
    @(negedge clk);
    check("t5_tag0_nowake", issue_valid, 1'b0);
    check("t5_count1",      count,       4'd1);
    cyc();
    wake_valid  = 2'b00;
    flush_valid = 1'b1;
    flush_mask  = 8'h20;
    cyc();
    flush_valid = 1'b0;
    flush_mask  = '0;
    @(negedge clk);
    check("t5_count0", count, 4'd0);
    cyc();

    // Reset mid-stream overrides a dispatch in progress
    for (int i = 0; i < 5; i++) begin
      disp(7'(30 + i), 1'b0, 7'd0, 1'b1, 3'd0, 3'(i), 96'hF00 + 96'(i), 1'b0);
      cyc();
    end
    disp(7'd60, 1'b1, 7'd0, 1'b1, 3'd1, 3'd6, 96'hF60, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_pre_rst_count", count, 4'd5);
    cyc();
    rst        = 1'b0;
    disp_valid = 1'b0;
    @(negedge clk);
    check("t6_rst_count",   count,         4'd0);
    check("t6_rst_iv",      issue_valid,   1'b0);
    check("t6_rst_ready",   disp_ready,    1'b1);
    check("t6_rst_payload", issue_payload, 96'd0);
    // fu_ready gates the request
    fu_ready = 8'h7F;
    disp(7'd61, 1'b1, 7'd0, 1'b1, 3'd7, 3'd7, 96'hF61, 1'b1);
    cyc();
    disp_valid = 1'b0;
    @(negedge clk);
    check("t6_fu_blocked", issue_valid, 1'b0);
    check("t6_count1",     count,       4'd1);
    cyc();
    fu_ready = 8'hFF;
    @(negedge clk);
    check("t6_fu_ready_iss", issue_valid, 1'b1);
    cyc();
    @(negedge clk);
    check("t6_count0", count, 4'd0);

    repeat (3) cyc();
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/issue_queue_age.md
# issue_queue_age

Parametrised out-of-order issue queue with an age-matrix oldest-ready select, N wakeup broadcast ports and ROB-mask flush. It sits between the rename/dispatch stage and register read. It is the successor of the fixed 4-entry, 2-wakeup issue stage: depth, tag width, ROB width, functional-unit count and wakeup port count are all parameters. Payload is opaque, and register read is done downstream.

## Interface
- DEPTH, 8: entry count, ≥2.
- PTAG_W, 7: physical register tag width; tag 0 is the hardwired zero register.
- ROB_W, 3: ROB index width; the flush mask is 2**ROB_W bits.
- NUM_FU, 8: functional-unit count; FU_W = $clog2(NUM_FU).
- NUM_WAKE, 2: wakeup broadcast ports.
- PAYLOAD_W, 96: opaque payload width (pc, imm, op, f3, f7, rd, ld/st idx, jump).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  a free entry exists.
- disp_rs1, disp_rs2  in  PTAG_W each  source tags.
- disp_rs1_rdy, disp_rs2_rdy  in  1 each  source ready bits from the rename busy table.
- disp_fu_sel  in  FU_W  target functional unit.
- disp_rob_idx  in  ROB_W  ROB index.
- disp_payload  in  PAYLOAD_W  opaque payload.
- wake_valid  in  NUM_WAKE  per-port tag broadcast valid.
- wake_tag  in  NUM_WAKE*PTAG_W  broadcast tags; port k occupies bits [k*PTAG_W +: PTAG_W].
- fu_ready  in  NUM_FU  per-unit accept.
- issue_valid  out  1  an entry is granted this cycle.
- issue_ready  in  1  downstream accepts.
- issue_rs1, issue_rs2  out  PTAG_W each  source tags of the granted entry.
- issue_fu_sel  out  FU_W  functional unit of the granted entry.
- issue_rob_idx  out  ROB_W  ROB index of the granted entry.
- issue_payload  out  PAYLOAD_W  payload of the granted entry.
- flush_valid  in  1  mispredict flush.
- flush_mask  in  2**ROB_W  ROB indices to kill.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Entry state: valid, rs1/rs2 tags, rs1/rs2 ready, fu_sel, rob_idx, payload.
- Age matrix: age[i][j]=1 means entry i is older than entry j.
- Wake hit: a source tag equal to any valid wake port tag with a nonzero tag. Tag 0 never wakes anything; it is ready only through disp_rdy.
- Source effectively ready: stored ready bit OR wake hit this cycle.
- Request: entry valid, both sources effectively ready, fu_ready[fu_sel]=1, and the entry is not killed this cycle.
- Killed: flush_valid && flush_mask[rob_idx].
- Grant: the requester with no older requester. If the age matrix has a tie because of corruption, the lowest index wins.
- issue_valid = OR of requests. All issue_* outputs are muxed from the granted entry; when issue_valid=0 they are zero.
- Entry freed on the edge where issue_valid && issue_ready.
- Wakeup: every valid entry's ready bits OR in wake hits every cycle.
- Dispatch: writes the lowest-index free entry when disp_valid && disp_ready.
  - Stored ready bits = disp_rdy OR same-cycle wake hit.
  - Age row of the new entry is cleared; its column is set for every entry that stays valid.
- Flush: killed entries are invalidated. A dispatch whose disp_rob_idx is masked during flush_valid is dropped, but the handshake still completes.
- Flush has priority over issue on the same entry: that entry is not requested, so the issue goes to the next-oldest requester.
- disp_ready = count < DEPTH. A slot freed by an issue in the same cycle is not reused until the next cycle.
- count next value = count + dispatch_written − issued − flushed.

## Timing
- Reset, applied at any time, leaves:
  - all entries invalid, age matrix zero, count=0;
  - issue_valid=0, all issue_* outputs zero, disp_ready=1.
  - Reset overrides a dispatch, issue or flush in progress.
- Dispatch to earliest issue: 1 cycle. An entry written at edge T can issue combinationally in cycle T+1.
- Wakeup to issue: 0 cycles. A tag broadcast in cycle C lets a waiting entry issue in cycle C.
- issue_valid may drop without handshake when fu_ready or a wake input changes. Downstream must sample only in the handshake cycle.
- Full: dispatch stalls while count=DEPTH. Empty: issue_valid=0.
- Simultaneous dispatch, issue and flush in one cycle each update independent entries. count reflects all three.

## Test plan
- Reset, then dispatch tags rs1=5, rs2=0 with rdy=1/1, fu=2, fu_ready all 1, issue_ready=1 → issue_valid in the next cycle, issue_rs1=5, count 1→0.
- Dispatch A (rs1=9, not ready), then B (ready), then C (ready); broadcast tag 9 on port 1 → in that cycle A issues first (oldest), then B, then C on consecutive cycles.
- Fill all DEPTH=8 entries with not-ready ops → disp_ready=0, count=8. Wake one entry → it issues, disp_ready=1 in the following cycle, and the next dispatch lands in the freed index.
- 3 ready entries with rob_idx 1, 2, 3; pulse flush_mask=8'b0000_0110 → count drops 3→1 and only rob 3 issues, even though rob 1 is the oldest.
- Dispatch rs2=12 while wake_tag=12 in the same cycle → entry stored ready and issues the next cycle; wake_tag=0 with wake_valid=1 wakes nothing.
- Assert rst mid-stream with 5 entries valid → next cycle count=0, issue_valid=0, disp_ready=1.
